// File: rtl/bitcoin_hash_batched_if.sv
// Word-memory bus shared by the hash engines.
//   mem_clk        : memory clock, driven by the engine from its own clk
//   mem_we         : write enable
//   mem_addr       : word address
//   mem_write_data : write data
//   mem_read_data  : read data, valid one cycle after mem_addr
// master = hash engine, slave = memory.
interface bitcoin_hash_batched_if #(
    parameter int ADDR_W = 16
);
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output mem_clk, mem_we, mem_addr, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk, mem_we, mem_addr, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/bitcoin_hash_batched.sv
// Double-SHA256 nonce sweep over one 80-byte header (19 words in memory).
// The first block is hashed once into a midstate; then NUM_NONCES nonces are
// swept in batches of LANES parallel lanes, each lane running block 2 (tail +
// nonce) and block 3 (second hash). Final digest word 0 of every nonce is
// written back and compared against target; the lowest hitting nonce is kept.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   start                     : level request, sampled only in IDLE
//   message_addr, output_addr : header base / result base word addresses
//   nonce_base, target        : nonce of sweep index 0, unsigned hit threshold
//   done                      : one-cycle pulse at end of sweep
//   found, found_nonce        : hit flag and lowest hitting nonce
//   dbg_state                 : current FSM state
//   mem                       : word-memory bus (master side)
// Handshake: start acts as valid and IDLE acts as ready, so a start seen in any
// other state is dropped; done pulses once per accepted start; memory read data
// arrives one cycle after mem_addr and a write commits on the edge where mem_we=1.
module bitcoin_hash_batched #(
    parameter int NUM_NONCES = 16,
    parameter int LANES      = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     message_addr,
    input  logic [ADDR_W-1:0]     output_addr,
    input  logic [31:0]           nonce_base,
    input  logic [31:0]           target,
    output logic                  done,
    output logic                  found,
    output logic [31:0]           found_nonce,
    output logic [2:0]            dbg_state,
    bitcoin_hash_batched_if.master mem
);
    localparam int B = NUM_NONCES / LANES;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_BLK1, S_MID, S_BLK2, S_BLK3, S_WRITE, S_DONE
    } state_e;
    typedef logic [7:0][31:0]  hv_t;
    typedef logic [15:0][31:0] win_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    // Index 0 holds H0 (word a).
    localparam hv_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hv_t sha_round(input hv_t s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1, t2;
        hv_t r;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        r = {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
        return r;
    endfunction

    // Window holds W[t..t+15]; this produces W[t+16].
    function automatic logic [31:0] sched_next(input win_t w);
        return w[0] + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[9]
             + (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10));
    endfunction

    function automatic hv_t add8(input hv_t x, input hv_t y);
        hv_t r;
        for (int i = 0; i < 8; i++) r[i] = x[i] + y[i];
        return r;
    endfunction

    function automatic logic [31:0] lane_nonce(input logic [31:0] base, input logic [31:0] b, input int l);
        return base + b * 32'(LANES) + 32'(l);
    endfunction

    function automatic win_t blk2_win(input logic [2:0][31:0] t, input logic [31:0] n);
        win_t r = '0;
        r[0] = t[0]; r[1] = t[1]; r[2] = t[2]; r[3] = n;
        r[4] = 32'h80000000; r[15] = 32'd640;
        return r;
    endfunction

    function automatic win_t blk3_win(input hv_t d);
        win_t r = '0;
        for (int i = 0; i < 8; i++) r[i] = d[i];
        r[8] = 32'h80000000; r[15] = 32'd256;
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [6:0]              cnt_q, cnt_d;
    logic [31:0]             b_q, b_d;
    logic [ADDR_W-1:0]       msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0]             nbase_q, nbase_d, target_q, target_d;
    logic [2:0][31:0]        tail_q, tail_d;
    hv_t                     mid_q, mid_d;
    hv_t  [LANES-1:0]        hv_q, hv_d, round_out;
    win_t [LANES-1:0]        w_q, w_d, w_shift;
    logic [LANES-1:0][31:0]  fin_q, fin_d;
    logic                    found_q, found_d, done_q, done_d, mem_we_q, mem_we_d;
    logic [31:0]             found_nonce_q, found_nonce_d, mem_wd_q, mem_wd_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; b_d = b_q;
        msg_addr_d = msg_addr_q; out_addr_d = out_addr_q;
        nbase_d = nbase_q; target_d = target_q; tail_d = tail_q; mid_d = mid_q;
        hv_d = hv_q; w_d = w_q; fin_d = fin_q;
        found_d = found_q; found_nonce_d = found_nonce_q; done_d = 1'b0;
        mem_we_d = mem_we_q; mem_addr_d = mem_addr_q; mem_wd_d = mem_wd_q;
        for (int l = 0; l < LANES; l++) begin
            round_out[l] = sha_round(hv_q[l], w_q[l][0], K[cnt_q[5:0]]);
            w_shift[l]   = {sched_next(w_q[l]), w_q[l][15:1]};
        end
        case (state_q)
            S_IDLE: if (start) begin
                msg_addr_d = message_addr; out_addr_d = output_addr;
                nbase_d = nonce_base; target_d = target;
                found_d = 1'b0; found_nonce_d = '0; b_d = '0; cnt_d = '0;
                mem_addr_d = message_addr;
                state_d = S_READ;
            end
            S_READ: begin
                // Cycle c returns header word c-1.
                cnt_d = cnt_q + 7'd1;
                if (cnt_q < 7'd18) mem_addr_d = msg_addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                if (cnt_q >= 7'd1 && cnt_q <= 7'd16)
                    for (int l = 0; l < LANES; l++) w_d[l] = {mem.mem_read_data, w_q[l][15:1]};
                if (cnt_q >= 7'd17) tail_d = {mem.mem_read_data, tail_q[2:1]};
                if (cnt_q == 7'd19) begin
                    cnt_d = '0;
                    for (int l = 0; l < LANES; l++) hv_d[l] = IV;
                    state_d = S_BLK1;
                end
            end
            S_BLK1, S_BLK2, S_BLK3: begin
                // Every lane rounds in BLK1 too; only lane 0 feeds the midstate.
                cnt_d = cnt_q + 7'd1;
                hv_d = round_out;
                w_d  = w_shift;
                if (cnt_q == 7'd63) begin
                    cnt_d = '0;
                    if (state_q == S_BLK1) begin
                        state_d = S_MID;
                    end else if (state_q == S_BLK2) begin
                        for (int l = 0; l < LANES; l++) begin
                            hv_d[l] = IV;
                            w_d[l]  = blk3_win(add8(mid_q, round_out[l]));
                        end
                        state_d = S_BLK3;
                    end else begin
                        // Ascending lane scan keeps the lowest sweep index on ties.
                        for (int l = 0; l < LANES; l++) begin
                            fin_d[l] = IV[0] + round_out[l][0];
                            if (!found_d && fin_d[l] < target_q) begin
                                found_d = 1'b1;
                                found_nonce_d = lane_nonce(nbase_q, b_q, l);
                            end
                        end
                        mem_we_d   = 1'b1;
                        mem_addr_d = out_addr_q + ADDR_W'(b_q * 32'(LANES));
                        mem_wd_d   = fin_d[0];
                        state_d    = S_WRITE;
                    end
                end
            end
            S_MID: begin
                mid_d = add8(IV, hv_q[0]);
                for (int l = 0; l < LANES; l++) begin
                    hv_d[l] = mid_d;
                    w_d[l]  = blk2_win(tail_q, lane_nonce(nbase_q, b_q, l));
                end
                cnt_d = '0;
                state_d = S_BLK2;
            end
            S_WRITE: begin
                cnt_d = cnt_q + 7'd1;
                if (int'(cnt_q) < LANES - 1) begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    for (int l = 0; l < LANES; l++)
                        if (l == int'(cnt_q) + 1) mem_wd_d = fin_q[l];
                end else if (int'(cnt_q) == LANES - 1) begin
                    mem_we_d = 1'b0;
                end else begin
                    cnt_d = '0;
                    if (b_q == 32'(B - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        b_d = b_q + 32'd1;
                        for (int l = 0; l < LANES; l++) begin
                            hv_d[l] = mid_q;
                            w_d[l]  = blk2_win(tail_q, lane_nonce(nbase_q, b_q + 32'd1, l));
                        end
                        state_d = S_BLK2;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE; cnt_q <= '0; b_q <= '0;
            msg_addr_q <= '0; out_addr_q <= '0; nbase_q <= '0; target_q <= '0;
            tail_q <= '0; mid_q <= '0; hv_q <= '0; w_q <= '0; fin_q <= '0;
            found_q <= 1'b0; found_nonce_q <= '0; done_q <= 1'b0;
            mem_we_q <= 1'b0; mem_addr_q <= '0; mem_wd_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; b_q <= b_d;
            msg_addr_q <= msg_addr_d; out_addr_q <= out_addr_d;
            nbase_q <= nbase_d; target_q <= target_d;
            tail_q <= tail_d; mid_q <= mid_d; hv_q <= hv_d; w_q <= w_d; fin_q <= fin_d;
            found_q <= found_d; found_nonce_q <= found_nonce_d; done_q <= done_d;
            mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wd_q <= mem_wd_d;
        end
    end

    assign done               = done_q;
    assign found              = found_q;
    assign found_nonce        = found_nonce_q;
    assign dbg_state          = state_q;
    assign mem.mem_clk        = clk;
    assign mem.mem_we         = mem_we_q;
    assign mem.mem_addr       = mem_addr_q;
    assign mem.mem_write_data = mem_wd_q;
endmodule

// File: tb/tb_bitcoin_hash_batched.sv
module tb_bitcoin_hash_batched;
    typedef logic [7:0][31:0]  hv_t;
    typedef logic [15:0][31:0] win_t;

    localparam int          N        = 16;
    localparam logic [15:0] MSG_ADDR = 16'h0010;
    localparam logic [15:0] OUT_ADDR = 16'h0040;
    // READ 20 + BLK1 64 + MID 1, then per batch BLK2 64 + BLK3 64 + WRITE (LANES+1).
    localparam int LAT4 = 20 + 64 + 1 + (N / 4) * (64 + 64 + 4 + 1);
    localparam int LAT1 = 20 + 64 + 1 + N * (64 + 64 + 1 + 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    // ---------------- clock / reset / DUTs ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] message_addr = MSG_ADDR, output_addr = OUT_ADDR;
    logic [31:0] nonce_base = '0, target = '0;
    logic        done0, found0, done1, found1;
    logic [31:0] fn0, fn1;
    logic [2:0]  dbg0, dbg1;

    always #5 clk = ~clk;

    bitcoin_hash_batched_if #(.ADDR_W(16)) mif0 ();
    bitcoin_hash_batched_if #(.ADDR_W(16)) mif1 ();

    bitcoin_hash_batched #(.NUM_NONCES(N), .LANES(4), .ADDR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .message_addr(message_addr), .output_addr(output_addr),
        .nonce_base(nonce_base), .target(target),
        .done(done0), .found(found0), .found_nonce(fn0), .dbg_state(dbg0), .mem(mif0)
    );

    bitcoin_hash_batched #(.NUM_NONCES(N), .LANES(1), .ADDR_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .message_addr(message_addr), .output_addr(output_addr),
        .nonce_base(nonce_base), .target(target),
        .done(done1), .found(found1), .found_nonce(fn1), .dbg_state(dbg1), .mem(mif1)
    );

    // ---------------- memories ----------------
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] hdr  [19];

    always @(posedge clk) begin
        mif0.mem_read_data <= mem0[mif0.mem_addr[7:0]];
        if (mif0.mem_we) mem0[mif0.mem_addr[7:0]] = mif0.mem_write_data;
    end
    always @(posedge clk) begin
        mif1.mem_read_data <= mem1[mif1.mem_addr[7:0]];
        if (mif1.mem_we) mem1[mif1.mem_addr[7:0]] = mif1.mem_write_data;
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q0 [$];
    logic [47:0] exp_q1 [$];
    logic [31:0] mw [N];

    always @(negedge clk) begin
        if (reset_n && mif0.mem_we) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected got addr=%h data=%h required no write", mif0.mem_addr, mif0.mem_write_data);
            end else if ({mif0.mem_addr, mif0.mem_write_data} !== exp_q0[0]) begin
                errors++;
                $display("FAIL wr0 got %h required %h", {mif0.mem_addr, mif0.mem_write_data}, exp_q0.pop_front());
            end else begin
                void'(exp_q0.pop_front());
            end
        end
    end
    always @(negedge clk) begin
        if (reset_n && mif1.mem_we) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected got addr=%h data=%h required no write", mif1.mem_addr, mif1.mem_write_data);
            end else if ({mif1.mem_addr, mif1.mem_write_data} !== exp_q1[0]) begin
                errors++;
                $display("FAIL wr1 got %h required %h", {mif1.mem_addr, mif1.mem_write_data}, exp_q1.pop_front());
            end else begin
                void'(exp_q1.pop_front());
            end
        end
    end

    // ---------------- reference model (FIPS 180-4 form) ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hv_t compress(input hv_t hin, input win_t blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        hv_t r;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[t];
            else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        for (int i = 0; i < 8; i++) v[i] = hin[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
        return r;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] n);
        hv_t iv, mid, d2, d3;
        win_t b1, b2, b3;
        for (int i = 0; i < 8; i++) iv[i] = H0[i];
        for (int i = 0; i < 16; i++) b1[i] = hdr[i];
        mid = compress(iv, b1);
        b2 = '0;
        b2[0] = hdr[16]; b2[1] = hdr[17]; b2[2] = hdr[18]; b2[3] = n;
        b2[4] = 32'h80000000; b2[15] = 32'd640;
        d2 = compress(mid, b2);
        b3 = '0;
        for (int i = 0; i < 8; i++) b3[i] = d2[i];
        b3[8] = 32'h80000000; b3[15] = 32'd256;
        d3 = compress(iv, b3);
        return d3[0];
    endfunction

    task automatic load_model(input logic [31:0] base);
        for (int i = 0; i < N; i++) mw[i] = model_word(base + 32'(i));
    endtask

    task automatic push_exp(input int which, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            if (which == 0) exp_q0.push_back({OUT_ADDR + 16'(i), mw[i]});
            else            exp_q1.push_back({OUT_ADDR + 16'(i), mw[i]});
        end
    endtask

    task automatic model_found(input logic [31:0] base, input logic [31:0] tgt,
                               output logic ef, output logic [31:0] efn);
        ef = 1'b0; efn = '0;
        for (int i = 0; i < N; i++)
            if (!ef && mw[i] < tgt) begin ef = 1'b1; efn = base + 32'(i); end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run0(input logic [31:0] base, input logic [31:0] tgt, input int glitch_at,
                        output int lat, output logic f, output logic [31:0] fn, output logic done_after);
        @(posedge clk); #1;
        nonce_base = base; target = tgt; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1;
            if (lat == glitch_at) begin
                start0 = 1'b1; nonce_base = ~base; target = ~tgt;
            end else if (glitch_at > 0 && lat == glitch_at + 1) begin
                start0 = 1'b0; nonce_base = base; target = tgt;
            end
        end while (!done0 && lat < 4000);
        f = found0; fn = fn0;
        @(posedge clk); #1;
        done_after = done0;
    endtask

    task automatic run1(input logic [31:0] base, input logic [31:0] tgt,
                        output int lat, output logic f, output logic [31:0] fn);
        @(posedge clk); #1;
        nonce_base = base; target = tgt; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1;
        end while (!done1 && lat < 4000);
        f = found1; fn = fn1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({done0, found0, mif0.mem_we} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b required 000", {done0, found0, mif0.mem_we});
        end
        checks++;
        if (mif0.mem_addr !== 16'h0 || mif0.mem_write_data !== 32'h0) begin
            errors++; $display("FAIL reset_bus got addr=%h data=%h required 0", mif0.mem_addr, mif0.mem_write_data);
        end
        checks++;
        if (fn0 !== 32'h0) begin errors++; $display("FAIL reset_found_nonce got %h required 0", fn0); end
        checks++;
        if (dbg0 !== 3'd0 || dbg1 !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d/%0d required 0/0", dbg0, dbg1);
        end
    endtask

    task automatic test_basic();
        int lat; logic f, da, ef; logic [31:0] fn, efn, tgt;
        tgt = $urandom;
        load_model(32'h0);
        model_found(32'h0, tgt, ef, efn);
        push_exp(0, 0, N);
        run0(32'h0, tgt, 0, lat, f, fn, da);
        checks++;
        if (lat !== LAT4) begin errors++; $display("FAIL basic_latency got %0d required %0d", lat, LAT4); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b required 0", da); end
        checks++;
        if (f !== ef || fn !== efn) begin errors++; $display("FAIL basic_found got %b/%h required %b/%h", f, fn, ef, efn); end
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL basic_writes left %0d required 0", exp_q0.size()); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem0[OUT_ADDR[7:0] + 8'(i)] !== mw[i]) begin
                errors++; $display("FAIL basic_image[%0d] got %h required %h", i, mem0[OUT_ADDR[7:0] + 8'(i)], mw[i]);
            end
        end
    endtask

    task automatic test_lanes_one();
        int lat; logic f, ef; logic [31:0] fn, efn, tgt;
        tgt = $urandom;
        load_model(32'h0);
        model_found(32'h0, tgt, ef, efn);
        push_exp(1, 0, N);
        run1(32'h0, tgt, lat, f, fn);
        checks++;
        if (lat !== LAT1) begin errors++; $display("FAIL lanes1_latency got %0d required %0d", lat, LAT1); end
        checks++;
        if (f !== ef || fn !== efn) begin errors++; $display("FAIL lanes1_found got %b/%h required %b/%h", f, fn, ef, efn); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem1[OUT_ADDR[7:0] + 8'(i)] !== mem0[OUT_ADDR[7:0] + 8'(i)] || mem1[OUT_ADDR[7:0] + 8'(i)] !== mw[i]) begin
                errors++; $display("FAIL lanes1_image[%0d] got %h required %h", i, mem1[OUT_ADDR[7:0] + 8'(i)], mw[i]);
            end
        end
    endtask

    task automatic test_target_extremes();
        int lat; logic f, da; logic [31:0] fn, base;
        base = $urandom;
        load_model(base);
        push_exp(0, 0, N);
        run0(base, 32'hFFFFFFFF, 0, lat, f, fn, da);
        checks++;
        if (f !== 1'b1 || fn !== base) begin errors++; $display("FAIL tgt_max got %b/%h required 1/%h", f, fn, base); end
        push_exp(0, 0, N);
        run0(base, 32'h0, 0, lat, f, fn, da);
        checks++;
        if (f !== 1'b0 || fn !== 32'h0) begin errors++; $display("FAIL tgt_zero got %b/%h required 0/0", f, fn); end
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL tgt_writes left %0d required 0", exp_q0.size()); end
    endtask

    task automatic test_target_mid();
        int lat; logic f, da, ef; logic [31:0] fn, efn, base, tgt;
        logic [31:0] s [$];
        base = $urandom;
        load_model(base);
        s = {};
        for (int i = 0; i < N; i++) s.push_back(mw[i]);
        s.sort();
        tgt = s[3];
        model_found(base, tgt, ef, efn);
        push_exp(0, 0, N);
        run0(base, tgt, 0, lat, f, fn, da);
        checks++;
        if (f !== ef || fn !== efn) begin errors++; $display("FAIL tgt_mid got %b/%h required %b/%h", f, fn, ef, efn); end
    endtask

    task automatic test_nonce_wrap();
        int lat; logic f, da, ef; logic [31:0] fn, efn, tgt;
        tgt = $urandom;
        load_model(32'hFFFFFFFE);
        model_found(32'hFFFFFFFE, tgt, ef, efn);
        push_exp(0, 0, N);
        run0(32'hFFFFFFFE, tgt, 0, lat, f, fn, da);
        checks++;
        if (f !== ef || fn !== efn) begin errors++; $display("FAIL wrap_found got %b/%h required %b/%h", f, fn, ef, efn); end
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL wrap_writes left %0d required 0", exp_q0.size()); end
    endtask

    task automatic test_reset_mid();
        int lat, dcount; logic f, da, ef; logic [31:0] fn, efn, base;
        base = $urandom;
        load_model(base);
        push_exp(0, 0, 4);
        @(posedge clk); #1;
        nonce_base = base; target = 32'hFFFFFFFF; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (230) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({done0, found0, mif0.mem_we} !== 3'b000 || fn0 !== 32'h0 || dbg0 !== 3'd0) begin
            errors++; $display("FAIL midrst_outputs got d=%b f=%b we=%b fn=%h st=%0d required zeros", done0, found0, mif0.mem_we, fn0, dbg0);
        end
        checks++;
        if (mif0.mem_addr !== 16'h0 || mif0.mem_write_data !== 32'h0) begin
            errors++; $display("FAIL midrst_bus got addr=%h data=%h required 0", mif0.mem_addr, mif0.mem_write_data);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL midrst_batch0 left %0d required 0", exp_q0.size()); end
        dcount = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        checks++;
        if (dcount != 0) begin errors++; $display("FAIL midrst_done got %0d pulses required 0", dcount); end
        model_found(base, 32'h80000000, ef, efn);
        push_exp(0, 0, N);
        run0(base, 32'h80000000, 0, lat, f, fn, da);
        checks++;
        if (lat !== LAT4 || f !== ef || fn !== efn) begin
            errors++; $display("FAIL midrst_rerun got %0d/%b/%h required %0d/%b/%h", lat, f, fn, LAT4, ef, efn);
        end
    endtask

    task automatic test_start_glitch();
        int lat; logic f, da, ef; logic [31:0] fn, efn, tgt;
        tgt = $urandom;
        load_model(32'h0);
        model_found(32'h0, tgt, ef, efn);
        push_exp(0, 0, N);
        run0(32'h0, tgt, 40, lat, f, fn, da);
        checks++;
        if (lat !== LAT4 || da !== 1'b0) begin errors++; $display("FAIL glitch_timing got %0d/%b required %0d/0", lat, da, LAT4); end
        checks++;
        if (f !== ef || fn !== efn) begin errors++; $display("FAIL glitch_found got %b/%h required %b/%h", f, fn, ef, efn); end
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL glitch_writes left %0d required 0", exp_q0.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem0[i] = '0; mem1[i] = '0; end
        for (int i = 0; i < 19; i++) begin
            hdr[i] = $urandom;
            mem0[MSG_ADDR[7:0] + 8'(i)] = hdr[i];
            mem1[MSG_ADDR[7:0] + 8'(i)] = hdr[i];
        end
        test_reset();
        test_basic();
        test_lanes_one();
        test_target_extremes();
        test_target_mid();
        test_nonce_wrap();
        test_reset_mid();
        test_start_glitch();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
